cia_eclk_sequencer: RTL

Sequences 6800-style synchronous peripheral (CIA) bus cycles against the 0.709 MHz E-clock produced by the master clock generator. Runs in the 7.09 MHz `clk` domain. Accepts a level request from the CPU bus interface and aligns it to the ten-phase `eclk` pulse train. Generates VMA, E, CIA select and data strobe, then returns a one-cycle acknowledge.

---
 rtl/cia_eclk_sequencer_pkg.sv | 22 ++
 rtl/cia_eclk_sequencer_eclk_watchdog.sv | 35 +++
 rtl/cia_eclk_sequencer.sv | 119 +++++++++++
 3 files changed

// File: rtl/cia_eclk_sequencer_pkg.sv
// Shared definitions for the CIA E-clock bus-cycle sequencer:
// FSM state encoding, E-clock phase indices and the default watchdog limit.
package cia_eclk_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC  = 3'd1,
    ST_VMA   = 3'd2,
    ST_EHIGH = 3'd3,
    ST_ACK   = 3'd4
  } state_t;

  // Phase at which SYNC may advance to VMA (last chance to join this E period)
  localparam int ECLK_VMA_IDX = 4;
  // Phase at which VMA advances to EHIGH (E rises on the following phase)
  localparam int ECLK_EHI_IDX = 5;
  // Phase during which the data strobe is active; the access ends here
  localparam int ECLK_STB_IDX = 9;

  localparam int WD_LIMIT_DEFAULT = 20;

endpackage

// File: rtl/cia_eclk_sequencer_eclk_watchdog.sv
// SYNC-state watchdog for the CIA E-clock sequencer. Counts cycles while
// 'run' is high and flags the last cycle before WD_LIMIT is reached, so the
// registered bus error lands exactly WD_LIMIT cycles after SYNC entry.
// Only instantiated when ECLK_WATCHDOG_EN is defined.
module eclk_watchdog
  import cia_eclk_sequencer_pkg::*;
#(
  parameter int WD_LIMIT = WD_LIMIT_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  output logic timeout
);

  localparam int CNT_W = $clog2(WD_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WD_LIMIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WD_LIMIT - 1);

  logic [CNT_W-1:0] count_reg;

  // Count while waiting in SYNC; any other state clears it so each entry starts at 0
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (!run) begin
      count_reg <= '0;
    end else if (count_reg != CNT_MAX) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign timeout = run && (count_reg == CNT_LAST);

endmodule

// File: rtl/cia_eclk_sequencer.sv
// CIA E-clock bus-cycle sequencer. Aligns a level request from the CPU bus
// interface to the ten-phase eclk pulse train and produces VMA, E, CIA select,
// read/write strobes and a one-cycle acknowledge. All outputs are registered
// from the next state, so each output window lines up with the eclk phases.
// Optional SYNC watchdog: define ECLK_WATCHDOG_EN.
module cia_eclk_sequencer
  import cia_eclk_sequencer_pkg::*;
#(
  parameter int WD_LIMIT = WD_LIMIT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [9:0] eclk,
  input  logic       req,
  input  logic       rw,
  output logic       ack,
  output logic       berr,
  output logic       vma,
  output logic       e,
  output logic       cia_sel,
  output logic       cia_rd_stb,
  output logic       cia_wr_stb,
  output logic       busy
);

  state_t state_reg, state_next;
  logic   rw_q;
  logic   wd_timeout;

  logic ack_next, berr_next, vma_next, e_next;
  logic sel_next, rd_stb_next, wr_stb_next, busy_next;

  // Phases 0..3 carry no event for this sequencer
  logic unused_eclk;
  assign unused_eclk = ^eclk[ECLK_VMA_IDX-1:0];

`ifdef ECLK_WATCHDOG_EN
  eclk_watchdog #(
    .WD_LIMIT(WD_LIMIT)
  ) u_eclk_watchdog (
    .clk    (clk),
    .reset_n(reset_n),
    .run    (state_reg == ST_SYNC),
    .timeout(wd_timeout)
  );
`else
  localparam int unused_wd_limit = WD_LIMIT;
  assign wd_timeout = 1'b0;
`endif

  // State register; direction is captured once, when the request is accepted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
      rw_q      <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_IDLE && req) begin
        rw_q <= rw;
      end
    end
  end

  // Next-state logic: abort wins over phase match, phase match wins over timeout
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (req) state_next = ST_SYNC;
      ST_SYNC: begin
        if (!req)                    state_next = ST_IDLE;
        else if (eclk[ECLK_VMA_IDX]) state_next = ST_VMA;
        else if (wd_timeout)         state_next = ST_IDLE;
      end
      ST_VMA: begin
        if (!req)                    state_next = ST_IDLE;
        else if (eclk[ECLK_EHI_IDX]) state_next = ST_EHIGH;
      end
      ST_EHIGH: if (eclk[ECLK_STB_IDX]) state_next = ST_ACK;
      ST_ACK:   state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Output decode from next state; strobes look one phase ahead to hit phase 9
  always_comb begin
    vma_next    = (state_next == ST_VMA) || (state_next == ST_EHIGH);
    sel_next    = (state_next == ST_EHIGH);
    rd_stb_next = (state_next == ST_EHIGH) && eclk[ECLK_STB_IDX-1] && rw_q;
    wr_stb_next = (state_next == ST_EHIGH) && eclk[ECLK_STB_IDX-1] && !rw_q;
    ack_next    = (state_next == ST_ACK);
    busy_next   = (state_next != ST_IDLE);
    berr_next   = (state_reg == ST_SYNC) && req && !eclk[ECLK_VMA_IDX] && wd_timeout;
    e_next      = |eclk[ECLK_STB_IDX-1:ECLK_EHI_IDX];
  end

  // Output registers; reset clears every output immediately
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack        <= 1'b0;
      berr       <= 1'b0;
      vma        <= 1'b0;
      e          <= 1'b0;
      cia_sel    <= 1'b0;
      cia_rd_stb <= 1'b0;
      cia_wr_stb <= 1'b0;
      busy       <= 1'b0;
    end else begin
      ack        <= ack_next;
      berr       <= berr_next;
      vma        <= vma_next;
      e          <= e_next;
      cia_sel    <= sel_next;
      cia_rd_stb <= rd_stb_next;
      cia_wr_stb <= wr_stb_next;
      busy       <= busy_next;
    end
  end

endmodule
